// File: rtl/uart_rx_frame.sv
// UART receiver: start + 7 data bits (LSB first) + optional parity + 1 stop.
// Delivers bytes through a one-entry valid/ready holding register and flags line errors.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [6:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DATA_W = 7;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    function automatic logic par_expected(input logic [DATA_W-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    state_t              state, state_nxt;
    logic                rx_sync_p0, rx_s;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [2:0]          idx, idx_nxt;
    logic [DATA_W-1:0]   sh, sh_nxt;
    logic                par, par_nxt;
    logic [DATA_W-1:0]   data_out_nxt;
    logic                data_valid_nxt;
    logic                frame_err_nxt, parity_err_nxt, overrun_nxt;
    logic                bit_end;

    // Stage p0/p1: two-flop synchronizer, idle-high so reset cannot fake a start
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_in;
            rx_s       <= rx_sync_p0;
        end
    end

    assign bit_end = (cnt == BIT_LAST);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + 1'b1;
        idx_nxt        = idx;
        sh_nxt         = sh;
        par_nxt        = par;
        data_out_nxt   = data_out;
        data_valid_nxt = data_valid;
        frame_err_nxt  = 1'b0;
        parity_err_nxt = 1'b0;
        overrun_nxt    = 1'b0;

        if (data_valid && data_ready) begin
            data_valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = DATA;
                        idx_nxt   = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt     = '0;
                    sh_nxt[idx] = rx_s;
                    if (idx == 3'd6) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    par_nxt   = rx_s;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    // Framing error takes precedence over a parity mismatch
                    if (!rx_s) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = WAIT_IDLE;
                    end else if ((PARITY_EN != 0) && (par != par_expected(sh))) begin
                        parity_err_nxt = 1'b1;
                        state_nxt      = IDLE;
                    end else begin
                        state_nxt = IDLE;
                        if (!data_valid || data_ready) begin
                            data_out_nxt   = sh;
                            data_valid_nxt = 1'b1;
                        end else begin
                            overrun_nxt = 1'b1;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Stage p2: control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 3'd0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            data_out   <= data_out_nxt;
            data_valid <= data_valid_nxt;
            frame_err  <= frame_err_nxt;
            parity_err <= parity_err_nxt;
            overrun    <= overrun_nxt;
        end
    end

    always_ff @(posedge clk) begin
        sh  <= sh_nxt;
        par <= par_nxt;
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: expected bytes and error pulses are queued
// when frames are driven and matched as the receiver produces them.
module tb_uart_rx_frame;

    localparam int BIT_CLKS = 16;
    localparam logic [7:0] EV_FERR = 8'd1;
    localparam logic [7:0] EV_PERR = 8'd2;
    localparam logic [7:0] EV_OVR  = 8'd3;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [6:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int n_checks;
    int n_fail;
    int dv_cycles;
    int busy_run;
    int busy_max;
    logic prev_ferr, prev_perr, prev_ovr;

    logic [6:0] data_q[$];
    logic [7:0] err_q[$];

    uart_rx_frame #(
        .CLKS_PER_BIT(BIT_CLKS),
        .PARITY_EN   (1),
        .PARITY_ODD  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [6:0] d, input logic par_ok, input logic stop);
        logic p;
        p = (^d) ^ ~par_ok;
        rx_in = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 7; i++) begin
            rx_in = d[i];
            tick(BIT_CLKS);
        end
        rx_in = p;
        tick(BIT_CLKS);
        rx_in = stop;
        tick(BIT_CLKS);
    endtask

    task automatic pop_err(input string tag, input logic [7:0] kind);
        if (err_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'(kind), 32'd0);
        end else begin
            check(tag, 32'(kind), 32'(err_q.pop_front()));
        end
    endtask

    always @(negedge clk) begin
        if (data_valid) dv_cycles++;
        if (busy) busy_run++;
        else busy_run = 0;
        if (busy_run > busy_max) busy_max = busy_run;

        if (data_valid && data_ready) begin
            if (data_q.size() == 0) check("data_unexpected", 32'(data_out), 32'hFFFF);
            else check("data_out", 32'(data_out), 32'(data_q.pop_front()));
        end
        if (frame_err) begin
            pop_err("frame_err", EV_FERR);
            check("frame_err_width", 32'(prev_ferr), 32'd0);
        end
        if (parity_err) begin
            pop_err("parity_err", EV_PERR);
            check("parity_err_width", 32'(prev_perr), 32'd0);
        end
        if (overrun) begin
            pop_err("overrun", EV_OVR);
            check("overrun_width", 32'(prev_ovr), 32'd0);
        end
        prev_ferr = frame_err;
        prev_perr = parity_err;
        prev_ovr  = overrun;
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        dv_cycles  = 0;
        busy_run   = 0;
        busy_max   = 0;
        prev_ferr  = 1'b0;
        prev_perr  = 1'b0;
        prev_ovr   = 1'b0;
        rst        = 1'b1;
        rx_in      = 1'b1;
        data_ready = 1'b0;
        tick(4);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_errs", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        rst = 1'b0;
        tick(4);

        // Bad parity: byte dropped, data_out still at its reset value
        data_ready = 1'b1;
        dv_cycles  = 0;
        err_q.push_back(EV_PERR);
        send_frame(7'h55, 1'b0, 1'b1);
        tick(4);
        check("perr_no_valid", 32'(dv_cycles), 32'd0);
        check("perr_data_kept", 32'(data_out), 32'h00);
        check("perr_idle", 32'(busy), 32'd0);

        // Good frame with consumer ready: single-cycle valid
        dv_cycles = 0;
        data_q.push_back(7'h55);
        send_frame(7'h55, 1'b1, 1'b1);
        tick(4);
        check("good_valid_cycles", 32'(dv_cycles), 32'd1);
        check("good_data", 32'(data_out), 32'h55);
        check("good_valid_low", 32'(data_valid), 32'd0);
        check("good_idle", 32'(busy), 32'd0);

        // Stop bit low and line held low: busy until the line returns high
        dv_cycles = 0;
        err_q.push_back(EV_FERR);
        send_frame(7'h2A, 1'b1, 1'b0);
        tick(40);
        check("ferr_busy_held", 32'(busy), 32'd1);
        rx_in = 1'b1;
        tick(4);
        check("ferr_idle_after", 32'(busy), 32'd0);
        check("ferr_no_valid", 32'(dv_cycles), 32'd0);

        // Short glitch rejected at the mid-start check
        dv_cycles = 0;
        busy_max  = 0;
        rx_in = 1'b0;
        tick(5);
        rx_in = 1'b1;
        tick(20);
        check("glitch_busy_le8", 32'(busy_max <= 8), 32'd1);
        check("glitch_busy_seen", 32'(busy_max > 0), 32'd1);
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(dv_cycles), 32'd0);

        // Back-to-back frames with consumer stalled: second byte overruns
        data_ready = 1'b0;
        data_q.push_back(7'h12);
        err_q.push_back(EV_OVR);
        send_frame(7'h12, 1'b1, 1'b1);
        send_frame(7'h34, 1'b1, 1'b1);
        tick(2);
        check("ovr_data_held", 32'(data_out), 32'h12);
        check("ovr_valid_held", 32'(data_valid), 32'd1);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        check("ovr_valid_cleared", 32'(data_valid), 32'd0);
        check("ovr_data_after", 32'(data_out), 32'h12);

        // Reset during DATA of 7'h7F, then a clean 7'h01
        data_ready = 1'b1;
        dv_cycles  = 0;
        rx_in = 1'b0;
        tick(BIT_CLKS);
        rx_in = 1'b1;
        tick(3 * BIT_CLKS);
        check("mid_frame_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        check("mid_rst_valid", 32'(data_valid), 32'd0);
        tick(6 * BIT_CLKS);
        check("lost_frame_no_valid", 32'(dv_cycles), 32'd0);
        data_q.push_back(7'h01);
        send_frame(7'h01, 1'b1, 1'b1);
        tick(4);
        check("after_rst_valid_cycles", 32'(dv_cycles), 32'd1);
        check("after_rst_data", 32'(data_out), 32'h01);

        tick(5);
        check("data_q_drained", 32'(data_q.size()), 32'd0);
        check("err_q_drained", 32'(err_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
